rx_frame_decoder: RTL and testbench
===================================

RX_FRAME_DECODER -- requirements
Module: rx_frame_decoder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the RX/TX FIFO byte width.
REQ-002 The block SHALL have parameter RX_FIFO_LOAD_W, default 11, meaning the RX FIFO load counter width.
REQ-003 The block SHALL have parameter TX_FIFO_LOAD_W, default 11, meaning the TX FIFO load counter width.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, meaning the maximum number of idle cycles allowed between bytes of one frame.
REQ-005 The block SHALL have ports clk (input, 1, system clock) and rst (input, 1, reset); one clock, reset synchronous and active-high.
REQ-006 The block SHALL have ports rxfifo_data (input, DATA_W, RX byte), rxfifo_valid (input, 1, byte valid), rxfifo_load (input, RX_FIFO_LOAD_W, unused except for debug), rxfifo_empty (input, 1, RX FIFO empty) and rxfifo_rd (output, 1, read strobe).
REQ-007 The block SHALL have ports txfifo_full (input, 1, TX FIFO full), txfifo_load (input, TX_FIFO_LOAD_W, unused), txfifo_wr (output, 1, write strobe) and txfifo_data (output, DATA_W, TX byte).
REQ-008 The block SHALL have ports latest_data (output, 32, last complete frame), phase_parse_en (output, 1, phase-frame strobe), phase_calib_en (output, 1, calibration-frame strobe) and read_error (output, 1, sticky protocol error).

Function
REQ-009 A frame SHALL be 4 bytes, first byte received = latest_data[31:24], the opcode byte; the last byte = [7:0].
REQ-010 Read handshake: the block SHALL assert rxfifo_rd for exactly one cycle when rxfifo_empty=0 and no read is outstanding; outstanding is set by rxfifo_rd and cleared on the cycle rxfifo_valid=1; a byte SHALL be captured only when rxfifo_valid=1.
REQ-011 The FSM SHALL have states COLLECT (byte_cnt 0..3), DISPATCH and TX_ACK.
REQ-012 COLLECT SHALL shift each captured byte into a 32-bit assembly register and increment byte_cnt; on the 4th byte it SHALL go to DISPATCH with byte_cnt wrapping to 0.
REQ-013 In DISPATCH (one cycle), the block SHALL load latest_data with the assembled word and decode opcode: 0x01 sets phase_parse_en, 0x02 sets phase_calib_en (registered, high for exactly the cycle after DISPATCH, while latest_data is already stable); 0x03 (ping) goes to TX_ACK; any other value sets read_error; all non-ping cases return to COLLECT.
REQ-014 latest_data SHALL hold its value until the next DISPATCH.
REQ-015 TX_ACK SHALL assert txfifo_wr for one cycle with txfifo_data = latest_data[7:0] XOR 0xA5 on the first cycle txfifo_full=0, then return to COLLECT; while txfifo_full=1 it SHALL wait with txfifo_wr=0.
REQ-016 No rxfifo_rd SHALL be issued in DISPATCH or TX_ACK; a read outstanding on entry SHALL still be captured into the next frame.
REQ-017 Timeout: in COLLECT with byte_cnt>0, a counter SHALL count cycles with no captured byte; on reaching TIMEOUT_CYCLES the partial frame SHALL be discarded, byte_cnt cleared and read_error set; the counter SHALL reset on every captured byte and whenever byte_cnt=0.
REQ-018 read_error SHALL remain high until rst.
REQ-019 phase_parse_en and phase_calib_en SHALL never be high in the same cycle.
REQ-020 Throughput: back-to-back bytes SHALL be accepted every 2 cycles minimum (rd, valid) with no byte dropped.

Reset
REQ-021 On rst=1, the block SHALL set state=COLLECT, byte_cnt=0, outstanding=0, timeout counter=0, latest_data=0, rxfifo_rd=0, txfifo_wr=0, txfifo_data=0, phase_parse_en=0, phase_calib_en=0 and read_error=0.
REQ-022 Reset mid-frame or mid-TX_ACK SHALL discard the partial frame and pending ack with no strobe emitted.

Structure
REQ-023 Opcode constants (OP_PHASE, OP_CALIB, OP_PING), PING_XOR=0xA5, FRAME_BYTES=4 and the FSM state enum SHALL live in the shared package.
REQ-024 The block SHALL have no sub-module; the timeout counter width SHALL be $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-025 Bytes 01 12 34 56 -> latest_data=0x01123456, phase_parse_en one pulse, read_error=0.
REQ-026 Bytes 02 00 07 FF -> phase_calib_en one pulse, latest_data=0x020007FF, phase_parse_en stays 0.
REQ-027 Bytes 03 00 00 5A with txfifo_full held 1 for 10 cycles -> no write during stall, then one txfifo_wr with data 0xFF, no further reads until written.
REQ-028 Bytes 7E 00 00 00 -> read_error=1 and stays 1; following frame 01 AA BB CC still yields phase_parse_en and latest_data=0x01AABBCC.
REQ-029 TIMEOUT_CYCLES=16: send 01 12, idle 20 cycles, then 01 00 00 09 -> read_error=1, latest_data=0x01000009, exactly one phase_parse_en.
REQ-030 rst asserted after 2 bytes of a frame, then frame 02 01 02 03 -> all outputs 0 during rst, then one phase_calib_en with latest_data=0x02010203.

Source files
------------

// File: rtl/rx_frame_decoder_pkg.sv
// Shared constants and types for the RX frame decoder: opcodes, framing and FSM encoding.
package rx_frame_decoder_pkg;

  localparam logic [7:0] OP_PHASE    = 8'h01;
  localparam logic [7:0] OP_CALIB    = 8'h02;
  localparam logic [7:0] OP_PING     = 8'h03;
  localparam logic [7:0] PING_XOR    = 8'hA5;
  localparam int         FRAME_BYTES = 4;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_DISPATCH,
    ST_TX_ACK
  } state_t;

  typedef enum logic [1:0] {
    OPK_PHASE,
    OPK_CALIB,
    OPK_PING,
    OPK_BAD
  } op_kind_t;

  function automatic op_kind_t decode_op(input logic [7:0] op);
    case (op)
      OP_PHASE: decode_op = OPK_PHASE;
      OP_CALIB: decode_op = OPK_CALIB;
      OP_PING:  decode_op = OPK_PING;
      default:  decode_op = OPK_BAD;
    endcase
  endfunction

endpackage

// File: rtl/rx_frame_decoder.sv
// Pulls 4-byte command frames from an RX FIFO, latches the last complete frame,
// strobes phase/calibration enables, answers pings through the TX FIFO.
module rx_frame_decoder
  import rx_frame_decoder_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int RX_FIFO_LOAD_W = 11,
  parameter int TX_FIFO_LOAD_W = 11,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         rxfifo_data,
  input  logic                      rxfifo_valid,
  input  logic [RX_FIFO_LOAD_W-1:0] rxfifo_load,
  input  logic                      rxfifo_empty,
  output logic                      rxfifo_rd,
  input  logic                      txfifo_full,
  input  logic [TX_FIFO_LOAD_W-1:0] txfifo_load,
  output logic                      txfifo_wr,
  output logic [DATA_W-1:0]         txfifo_data,
  output logic [31:0]               latest_data,
  output logic                      phase_parse_en,
  output logic                      phase_calib_en,
  output logic                      read_error
);

  localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]        CNT_LAST = 2'(FRAME_BYTES - 1);

  state_t           state;
  logic [1:0]       byte_cnt;
  logic             outstanding;
  logic [TMO_W-1:0] tmo_cnt;
  logic [31:0]      assembly;

  logic     capture;
  logic     last_byte;
  logic     issue_rd;
  op_kind_t op_kind;

  logic unused_load;
  assign unused_load = ^{rxfifo_load, txfifo_load, 1'b0};

  assign capture   = rxfifo_valid;
  assign last_byte = capture && (state == ST_COLLECT) && (byte_cnt == CNT_LAST);
  assign op_kind   = decode_op(assembly[31:24]);

  // A returning byte frees the slot in the same cycle, so a new read can follow
  // immediately and sustain one byte every two cycles.
  assign issue_rd = (state == ST_COLLECT) && !last_byte && !rxfifo_empty &&
                    !rxfifo_rd && (!outstanding || capture);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_COLLECT;
      byte_cnt       <= '0;
      outstanding    <= 1'b0;
      tmo_cnt        <= '0;
      assembly       <= '0;
      latest_data    <= '0;
      rxfifo_rd      <= 1'b0;
      txfifo_wr      <= 1'b0;
      txfifo_data    <= '0;
      phase_parse_en <= 1'b0;
      phase_calib_en <= 1'b0;
      read_error     <= 1'b0;
    end else begin
      rxfifo_rd      <= issue_rd;
      txfifo_wr      <= 1'b0;
      phase_parse_en <= 1'b0;
      phase_calib_en <= 1'b0;

      if (issue_rd)
        outstanding <= 1'b1;
      else if (capture)
        outstanding <= 1'b0;

      if (capture)
        assembly <= {assembly[31-DATA_W:0], rxfifo_data};

      case (state)
        ST_COLLECT: begin
          if (capture) begin
            tmo_cnt <= '0;
            if (byte_cnt == CNT_LAST) begin
              byte_cnt <= '0;
              state    <= ST_DISPATCH;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end else if (byte_cnt == '0) begin
            tmo_cnt <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_cnt    <= '0;
            byte_cnt   <= '0;
            read_error <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        ST_DISPATCH: begin
          tmo_cnt     <= '0;
          latest_data <= assembly;
          if (capture && byte_cnt != CNT_LAST)
            byte_cnt <= byte_cnt + 2'd1;
          case (op_kind)
            OPK_PHASE: begin
              phase_parse_en <= 1'b1;
              state          <= ST_COLLECT;
            end
            OPK_CALIB: begin
              phase_calib_en <= 1'b1;
              state          <= ST_COLLECT;
            end
            OPK_PING: state <= ST_TX_ACK;
            default: begin
              read_error <= 1'b1;
              state      <= ST_COLLECT;
            end
          endcase
        end

        ST_TX_ACK: begin
          tmo_cnt <= '0;
          // A late byte from a read issued before the frame closed opens the next frame.
          if (capture && byte_cnt != CNT_LAST)
            byte_cnt <= byte_cnt + 2'd1;
          if (!txfifo_full) begin
            txfifo_wr   <= 1'b1;
            txfifo_data <= DATA_W'(latest_data[7:0] ^ PING_XOR);
            state       <= ST_COLLECT;
          end
        end

        default: state <= ST_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_decoder.sv
// Directed bench for rx_frame_decoder with a behavioural RX FIFO and strobe monitors.
module tb_rx_frame_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rxfifo_data = '0;
  logic        rxfifo_valid = 1'b0;
  logic [10:0] rxfifo_load = '0;
  logic        rxfifo_empty;
  logic        rxfifo_rd;
  logic        txfifo_full = 1'b0;
  logic [10:0] txfifo_load = '0;
  logic        txfifo_wr;
  logic [7:0]  txfifo_data;
  logic [31:0] latest_data;
  logic        phase_parse_en;
  logic        phase_calib_en;
  logic        read_error;

  rx_frame_decoder #(
    .DATA_W        (8),
    .RX_FIFO_LOAD_W(11),
    .TX_FIFO_LOAD_W(11),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rxfifo_data   (rxfifo_data),
    .rxfifo_valid  (rxfifo_valid),
    .rxfifo_load   (rxfifo_load),
    .rxfifo_empty  (rxfifo_empty),
    .rxfifo_rd     (rxfifo_rd),
    .txfifo_full   (txfifo_full),
    .txfifo_load   (txfifo_load),
    .txfifo_wr     (txfifo_wr),
    .txfifo_data   (txfifo_data),
    .latest_data   (latest_data),
    .phase_parse_en(phase_parse_en),
    .phase_calib_en(phase_calib_en),
    .read_error    (read_error)
  );

  always #5 clk = ~clk;

  // RX FIFO model: read strobe pops, byte shows up with valid on the next cycle.
  logic [7:0]  rx_mem [0:63];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  assign rxfifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    rxfifo_valid <= 1'b0;
    if (rxfifo_rd && wr_ptr != rd_ptr) begin
      rxfifo_data  <= rx_mem[rd_ptr % 64];
      rxfifo_valid <= 1'b1;
      rd_ptr       <= rd_ptr + 1;
    end
  end

  int unsigned n_parse = 0, n_calib = 0, n_both = 0, n_wr = 0, n_wr_full = 0, n_rd = 0;
  logic [31:0] parse_data = '0, calib_data = '0;
  logic [7:0]  wr_data = '0;

  always @(negedge clk) begin
    if (phase_parse_en) begin n_parse++; parse_data = latest_data; end
    if (phase_calib_en) begin n_calib++; calib_data = latest_data; end
    if (phase_parse_en && phase_calib_en) n_both++;
    if (txfifo_wr) begin
      n_wr++;
      wr_data = txfifo_data;
      if (txfifo_full) n_wr_full++;
    end
    if (rxfifo_rd) n_rd++;
  end

  int unsigned n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    rx_mem[wr_ptr % 64] = b;
    wr_ptr++;
  endtask

  task automatic push_frame(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    push(t[31:24]); push(t[23:16]); push(t[15:8]); push(t[7:0]);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int unsigned p0, c0, w0, r0;

  task automatic snap();
    p0 = n_parse; c0 = n_calib; w0 = n_wr; r0 = n_rd;
  endtask

  initial begin
    cycles(3);
    check("rst_latest", latest_data, 32'h0);
    check("rst_ctrl", {27'd0, rxfifo_rd, txfifo_wr, phase_parse_en, phase_calib_en, read_error}, 32'h0);
    check("rst_txdata", {24'd0, txfifo_data}, 32'h0);
    rst = 1'b0;

    // Phase frame
    snap();
    push_frame(32'h01123456);
    cycles(30);
    check("ph_pulse", n_parse - p0, 1);
    check("ph_data", parse_data, 32'h01123456);
    check("ph_latest", latest_data, 32'h01123456);
    check("ph_calib0", n_calib - c0, 0);
    check("ph_reads", n_rd - r0, 4);
    check("ph_err", {31'd0, read_error}, 0);

    // Calibration frame
    snap();
    push_frame(32'h020007FF);
    cycles(30);
    check("cal_pulse", n_calib - c0, 1);
    check("cal_data", calib_data, 32'h020007FF);
    check("cal_parse0", n_parse - p0, 0);
    check("cal_latest", latest_data, 32'h020007FF);

    // Ping with TX FIFO stalled, next frame already queued
    snap();
    txfifo_full = 1'b1;
    push_frame(32'h0300005A);
    push_frame(32'h01112233);
    cycles(12);
    check("ping_rd_pre", n_rd - r0, 4);
    cycles(10);
    check("ping_rd_stall", n_rd - r0, 4);
    check("ping_wr_stall", n_wr - w0, 0);
    txfifo_full = 1'b0;
    cycles(30);
    check("ping_wr", n_wr - w0, 1);
    check("ping_data", {24'd0, wr_data}, 32'hFF);
    check("ping_wr_full", n_wr_full, 0);
    check("ping_next", n_parse - p0, 1);
    check("ping_latest", latest_data, 32'h01112233);
    check("ping_err", {31'd0, read_error}, 0);

    // Reset mid-frame
    push(8'h02); push(8'h01);
    cycles(8);
    snap();
    rst = 1'b1;
    cycles(1);
    check("mrst_latest", latest_data, 32'h0);
    check("mrst_ctrl", {27'd0, rxfifo_rd, txfifo_wr, phase_parse_en, phase_calib_en, read_error}, 32'h0);
    check("mrst_txdata", {24'd0, txfifo_data}, 32'h0);
    cycles(2);
    rst = 1'b0;
    push_frame(32'h02010203);
    cycles(30);
    check("mrst_calib", n_calib - c0, 1);
    check("mrst_parse0", n_parse - p0, 0);
    check("mrst_latest2", latest_data, 32'h02010203);
    check("mrst_err", {31'd0, read_error}, 0);

    // Unknown opcode then recovery
    snap();
    push_frame(32'h7E000000);
    cycles(30);
    check("bad_err", {31'd0, read_error}, 1);
    check("bad_strobes", (n_parse - p0) + (n_calib - c0), 0);
    push_frame(32'h01AABBCC);
    cycles(30);
    check("bad_next", n_parse - p0, 1);
    check("bad_latest", latest_data, 32'h01AABBCC);
    check("bad_sticky", {31'd0, read_error}, 1);

    // Inter-byte timeout
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    check("tmo_err0", {31'd0, read_error}, 0);
    snap();
    push(8'h01); push(8'h12);
    cycles(30);
    check("tmo_err", {31'd0, read_error}, 1);
    check("tmo_latest0", latest_data, 32'h0);
    push_frame(32'h01000009);
    cycles(30);
    check("tmo_latest", latest_data, 32'h01000009);
    check("tmo_pulse", n_parse - p0, 1);
    check("tmo_sticky", {31'd0, read_error}, 1);

    check("excl", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
